// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: per-frame arbiter sharing the byte-wide Tx path into framing.
// A winner owns the path until its last byte is accepted or the frame is aborted
// after MAX_GAP idle granted cycles. New grants wait for rx_active and tx_busy.
// Build macro TX_ARB_ROUND_ROBIN_EN: round-robin winner search with a registered
// last-grant pointer; left undefined, index 0 has fixed highest priority.
module tx_frame_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned MAX_GAP = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [NUM_REQ-1:0]   req_append_crc,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 out_append_crc,
  output logic                 out_abort,
  input  logic                 tx_busy,
  input  logic                 rx_active,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 frame_done
);

  localparam int unsigned IDX_W     = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [7:0]  GAP_LIMIT = 8'(MAX_GAP);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [7:0]         gap_q, gap_d;
  logic [7:0]         gap_inc;
  logic               crc_q, crc_d;
  logic               abort_q, abort_d;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   search_idx;
  logic               found;
  logic               xfer;

`ifdef TX_ARB_ROUND_ROBIN_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
`endif

  // Winner search over all requesters, first valid index in search order wins.
  always_comb begin
    winner     = '0;
    search_idx = '0;
    found      = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef TX_ARB_ROUND_ROBIN_EN
      search_idx = IDX_W'((32'(last_grant_q) + 32'd1 + k) % NUM_REQ);
`else
      search_idx = IDX_W'(k);
`endif
      if (!found && req_valid[search_idx]) begin
        found  = 1'b1;
        winner = search_idx;
      end
    end
  end

  // Byte path: pure mux of the granted requester, all zero when nothing is granted.
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) begin
        out_valid = req_valid[k];
        out_last  = req_last[k];
        out_data  = req_data[8*k +: 8];
      end
    end
  end

  assign xfer           = out_valid & out_ready;
  assign req_ready      = grant_q & {NUM_REQ{out_ready}};
  assign grant          = grant_q;
  assign out_append_crc = crc_q;
  assign out_abort      = abort_q;
  assign frame_done     = xfer & out_last;
  assign gap_inc        = gap_q + 8'd1;

  // Next-state logic: grant on idle request, hold per frame, drain before re-arbitrating.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gap_d   = gap_q;
    crc_d   = crc_q;
    abort_d = 1'b0;
`ifdef TX_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found && !rx_active && !tx_busy) begin
          state_d         = GRANT;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          gap_d           = '0;
          crc_d           = req_append_crc[winner];
`ifdef TX_ARB_ROUND_ROBIN_EN
          last_grant_d    = winner;
`endif
        end
      end
      GRANT: begin
        // A transfer clears the gap count, so the last-byte and abort paths never collide.
        if (xfer) begin
          gap_d = '0;
          if (out_last) begin
            state_d = DRAIN;
            grant_d = '0;
          end
        end else if (!out_valid) begin
          gap_d = gap_inc;
          if (gap_inc == GAP_LIMIT) begin
            state_d = DRAIN;
            grant_d = '0;
            gap_d   = '0;
            abort_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      gap_q   <= '0;
      crc_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gap_q   <= gap_d;
      crc_q   <= crc_d;
      abort_q <= abort_d;
    end
  end

`ifdef TX_ARB_ROUND_ROBIN_EN
  // Round-robin pointer, reset so the first search starts at index 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= LAST_IDX;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// tb_tx_frame_arbiter: directed timing scenarios plus randomized frame rounds
// checked against a frame-order/byte-stream reference model.
module tb_tx_frame_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned GAP  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_append_crc;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_last;
  logic              out_ready;
  logic              out_append_crc;
  logic              out_abort;
  logic              tx_busy;
  logic              rx_active;
  logic [NREQ-1:0]   grant;
  logic              frame_done;

  tx_frame_arbiter #(.NUM_REQ(NREQ), .MAX_GAP(GAP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_last       (req_last),
    .req_append_crc (req_append_crc),
    .req_ready      (req_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_last       (out_last),
    .out_ready      (out_ready),
    .out_append_crc (out_append_crc),
    .out_abort      (out_abort),
    .tx_busy        (tx_busy),
    .rx_active      (rx_active),
    .grant          (grant),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_abort  = 0;
  int          n_done   = 0;
  int          cyc      = 0;
  int          m_last;
  int unsigned hold_cnt [NREQ];
  logic        sb_en;
  logic        rnd_en;

  // Requester frames: {append_crc, last, data}
  logic [9:0]  rq0[$];
  logic [9:0]  rq1[$];
  logic [9:0]  exp_q[$];

  logic [NREQ-1:0] s_grant, s_ready;
  logic            s_valid, s_last, s_crc, s_abort, s_done, s_xfer;
  logic [7:0]      s_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int qsize(input int i);
    if (i == 0) return rq0.size();
    return rq1.size();
  endfunction

  function automatic logic [9:0] qfront(input int i);
    if (i == 0) return rq0[0];
    return rq1[0];
  endfunction

  task automatic qpush(input int i, input logic [9:0] v);
    if (i == 0) rq0.push_back(v);
    else        rq1.push_back(v);
  endtask

  task automatic qpop(input int i);
    if (i == 0) void'(rq0.pop_front());
    else        void'(rq1.pop_front());
  endtask

  task automatic drive_reqs();
    logic [9:0] f;
    for (int i = 0; i < NREQ; i++) begin
      if (qsize(i) != 0 && hold_cnt[i] == 0) begin
        f = qfront(i);
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = f[7:0];
        req_last[i]        = f[8];
        req_append_crc[i]  = f[9];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
        req_append_crc[i]  = 1'b0;
      end
    end
  endtask

  // One clock cycle: drive requesters, sample mid-cycle, score, advance queues.
  task automatic step();
    logic [9:0] e;
    drive_reqs();
    #4;
    s_grant = grant;
    s_ready = req_ready;
    s_valid = out_valid;
    s_data  = out_data;
    s_last  = out_last;
    s_crc   = out_append_crc;
    s_abort = out_abort;
    s_done  = frame_done;
    s_xfer  = out_valid & out_ready;
    if (s_abort) n_abort++;
    if (s_done)  n_done++;
    if (sb_en && s_xfer) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_extra_xfer", {31'd0, s_xfer}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_data", {24'd0, s_data}, {24'd0, e[7:0]});
        check_eq("sb_last", {31'd0, s_last}, {31'd0, e[8]});
        check_eq("sb_crc",  {31'd0, s_crc},  {31'd0, e[9]});
        check_eq("sb_done", {31'd0, s_done}, {31'd0, e[8]});
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (hold_cnt[i] != 0) hold_cnt[i]--;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        e = qfront(i);
        qpop(i);
        if (rnd_en && !e[8]) hold_cnt[i] = $urandom_range(0, GAP - 1);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_xfer(input int bound, input string tag);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!s_xfer && k < bound);
    if (!s_xfer) check_eq({tag, "_timeout"}, {31'd0, s_xfer}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int owner, c0, c1, prev, g, frames, done0, abort0, len;
    int unsigned mask;
    int order[$];
    logic [7:0] eb;
    logic [9:0] ent;
    logic crc;

    rst_n = 1'b0; out_ready = 1'b1; tx_busy = 1'b0; rx_active = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0; req_append_crc = '0;
    sb_en = 1'b0; rnd_en = 1'b0;
    for (int i = 0; i < NREQ; i++) hold_cnt[i] = 0;
    @(posedge clk); #1;

    // Reset state
    idle(2);
    rst_n = 1'b1;
    step();
    check_eq("rst_grant", {30'd0, s_grant}, 32'd0);
    check_eq("rst_valid", {31'd0, s_valid}, 32'd0);
    check_eq("rst_data",  {24'd0, s_data},  32'd0);
    check_eq("rst_crc",   {31'd0, s_crc},   32'd0);
    check_eq("rst_abort", {31'd0, s_abort}, 32'd0);
    check_eq("rst_done",  {31'd0, s_done},  32'd0);

    // Single frame from requester 1 with CRC
    qpush(1, {1'b1, 1'b0, 8'h50});
    qpush(1, {1'b1, 1'b1, 8'h00});
    step();
    check_eq("sf_idle_grant", {30'd0, s_grant}, 32'd0);
    step();
    check_eq("sf_grant",  {30'd0, s_grant}, 32'h2);
    check_eq("sf_valid",  {31'd0, s_valid}, 32'd1);
    check_eq("sf_data0",  {24'd0, s_data},  32'h50);
    check_eq("sf_last0",  {31'd0, s_last},  32'd0);
    check_eq("sf_ready",  {30'd0, s_ready}, 32'h2);
    check_eq("sf_crc",    {31'd0, s_crc},   32'd1);
    check_eq("sf_done0",  {31'd0, s_done},  32'd0);
    step();
    check_eq("sf_data1",  {24'd0, s_data},  32'h00);
    check_eq("sf_last1",  {31'd0, s_last},  32'd1);
    check_eq("sf_done1",  {31'd0, s_done},  32'd1);
    step();
    check_eq("sf_drain_grant", {30'd0, s_grant}, 32'd0);
    check_eq("sf_drain_valid", {31'd0, s_valid}, 32'd0);
    check_eq("sf_crc_hold",    {31'd0, s_crc},   32'd1);
    idle(3);

    // Contention: three one-byte frames from each requester, queued together
    for (int k = 0; k < 3; k++) begin
      qpush(0, {1'b0, 1'b1, 8'(8'hA0 + k)});
      qpush(1, {1'b0, 1'b1, 8'(8'hB0 + k)});
    end
    c0 = 0; c1 = 0; prev = 0;
    for (int f = 0; f < 6; f++) begin
`ifdef TX_ARB_ROUND_ROBIN_EN
      owner = f % 2;
`else
      owner = (f < 3) ? 0 : 1;
`endif
      if (owner == 0) begin eb = 8'(8'hA0 + c0); c0++; end
      else            begin eb = 8'(8'hB0 + c1); c1++; end
      wait_xfer(20, "cont_wait");
      check_eq("cont_grant", {30'd0, s_grant}, 32'd1 << owner);
      check_eq("cont_byte",  {24'd0, s_data},  {24'd0, eb});
      check_eq("cont_done",  {31'd0, s_done},  32'd1);
      if (f > 0) check_eq("b2b_spacing", cyc - prev, 32'd3);
      prev = cyc;
    end
    idle(3);

    // Gap abort after one byte, requester then silent for 10 cycles
    abort0 = n_abort; done0 = n_done;
    qpush(0, {1'b0, 1'b0, 8'h11});
    qpush(0, {1'b0, 1'b1, 8'h22});
    wait_xfer(10, "gap_first");
    hold_cnt[0] = 10;
    for (int k = 1; k <= 6; k++) begin
      step();
      check_eq($sformatf("gap_abort_%0d", k), {31'd0, s_abort}, (k == 5) ? 32'd1 : 32'd0);
      check_eq($sformatf("gap_grant_%0d", k), {30'd0, s_grant}, (k < 5) ? 32'd1 : 32'd0);
    end
    check_eq("gap_no_done", n_done - done0, 32'd0);
    check_eq("gap_one_abort", n_abort - abort0, 32'd1);
    rq0.delete();
    hold_cnt[0] = 0;
    idle(3);

    // Blocking by rx_active
    rx_active = 1'b1;
    qpush(0, {1'b0, 1'b1, 8'h33});
    g = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (s_grant != 0) g++;
    end
    check_eq("blk_no_grant", g, 32'd0);
    rx_active = 1'b0;
    step();
    check_eq("blk_fall_grant", {30'd0, s_grant}, 32'd0);
    step();
    check_eq("blk_grant", {30'd0, s_grant}, 32'h1);
    check_eq("blk_data",  {24'd0, s_data},  32'h33);
    idle(3);

    // Drain held by tx_busy
    qpush(0, {1'b0, 1'b1, 8'h44});
    wait_xfer(10, "drn_first");
    tx_busy = 1'b1;
    qpush(1, {1'b0, 1'b1, 8'h55});
    g = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (s_grant != 0) g++;
    end
    check_eq("drn_no_grant", g, 32'd0);
    tx_busy = 1'b0;
    step();
    check_eq("drn_f0_grant", {30'd0, s_grant}, 32'd0);
    step();
    check_eq("drn_f1_grant", {30'd0, s_grant}, 32'd0);
    step();
    check_eq("drn_f2_grant", {30'd0, s_grant}, 32'h2);
    check_eq("drn_f2_data",  {24'd0, s_data},  32'h55);
    idle(3);

    // Reset in the middle of a granted frame
    abort0 = n_abort; done0 = n_done;
    out_ready = 1'b0;
    qpush(0, {1'b1, 1'b0, 8'h66});
    qpush(0, {1'b1, 1'b1, 8'h67});
    idle(2);
    check_eq("mr_pre_grant", {30'd0, s_grant}, 32'h1);
    check_eq("mr_pre_crc",   {31'd0, s_crc},   32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    rq0.delete();
    out_ready = 1'b1;
    step();
    check_eq("mr_grant", {30'd0, s_grant}, 32'd0);
    check_eq("mr_valid", {31'd0, s_valid}, 32'd0);
    check_eq("mr_data",  {24'd0, s_data},  32'd0);
    check_eq("mr_crc",   {31'd0, s_crc},   32'd0);
    check_eq("mr_ready", {30'd0, s_ready}, 32'd0);
    check_eq("mr_no_abort", n_abort - abort0, 32'd0);
    check_eq("mr_no_done",  n_done - done0,   32'd0);
    idle(2);

    // Randomized rounds: model predicts frame order and the exact output byte stream
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m_last = NREQ - 1;
    sb_en = 1'b1; rnd_en = 1'b1;
    abort0 = n_abort; done0 = n_done; frames = 0;
    for (int r = 0; r < 30; r++) begin
      mask = $urandom_range(1, (1 << NREQ) - 1);
      order.delete();
`ifdef TX_ARB_ROUND_ROBIN_EN
      for (int k = 1; k <= NREQ; k++) begin
        if (((mask >> ((m_last + k) % NREQ)) & 1) != 0) order.push_back((m_last + k) % NREQ);
      end
      m_last = order[order.size() - 1];
`else
      for (int k = 0; k < NREQ; k++) begin
        if (((mask >> k) & 1) != 0) order.push_back(k);
      end
`endif
      foreach (order[j]) begin
        len = $urandom_range(1, 4);
        crc = 1'($urandom_range(0, 1));
        for (int b = 0; b < len; b++) begin
          ent = {crc, (b == len - 1), 8'($urandom_range(0, 255))};
          qpush(order[j], ent);
          exp_q.push_back(ent);
        end
        frames++;
      end
      g = 0;
      while ((rq0.size() != 0 || rq1.size() != 0 || exp_q.size() != 0) && g < 300) begin
        out_ready = ($urandom_range(0, 9) < 7);
        tx_busy   = ($urandom_range(0, 9) < 2);
        rx_active = ($urandom_range(0, 9) < 2);
        step();
        g++;
      end
      if (g >= 300) begin
        check_eq("rnd_round_timeout", exp_q.size(), 32'd0);
        break;
      end
      out_ready = 1'b1; tx_busy = 1'b0; rx_active = 1'b0;
      idle(2);
    end
    check_eq("rnd_no_abort", n_abort - abort0, 32'd0);
    check_eq("rnd_frames_done", n_done - done0, frames);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tx_frame_arbiter.md
# tx_frame_arbiter

Shares the single byte-wide Tx path into `framing` between up to four frame sources, for example `initialisation`, the 14443-4A layer and a future S-block/WTX generator. Grants are per frame: once a requester wins, it owns the path until its last byte is accepted or the frame is aborted. The arbiter also blocks new grants while a PCD frame is being received or `framing` is still serialising. It sits between the requesters and `framing`, in place of the Tx half of `routing`.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, legal range 2..4.
- `MAX_GAP`, default 64: maximum consecutive granted cycles with `req_valid` low before the frame is aborted. Legal range 1..255.

Ports:
- `clk`  in  1: 13.56 MHz recovered clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `req_valid`  in  NUM_REQ: requester i has a byte available.
- `req_data`  in  8*NUM_REQ: byte i is `req_data[8*i+7:8*i]`.
- `req_last`  in  NUM_REQ: byte i is the final byte of its frame.
- `req_append_crc`  in  NUM_REQ: requester i wants a CRC appended. Meaningful while `req_valid[i]` is high.
- `req_ready`  out  NUM_REQ: byte i is accepted this cycle.
- `out_valid`  out  1; `out_data`  out  8; `out_last`  out  1: byte stream to `framing`.
- `out_ready`  in  1: `framing` accepts the byte.
- `out_append_crc`  out  1: CRC request for the current frame.
- `out_abort`  out  1: one-cycle pulse; `framing` discards the partial frame.
- `tx_busy`  in  1: `framing` or 14443-2A is still transmitting.
- `rx_active`  in  1: a PCD frame is being received.
- `grant`  out  NUM_REQ: one-hot owner, or all zeros.
- `frame_done`  out  1: one-cycle pulse when the last byte is accepted.

## Operation
- FSM states are IDLE, GRANT and DRAIN. Reset state is IDLE.
- IDLE:
  - Condition: any `req_valid` is high, `rx_active` is 0 and `tx_busy` is 0.
  - On the condition, select a winner, register it in `grant`, go to GRANT, and latch `req_append_crc[winner]` into `out_append_crc`.
- GRANT:
  - `out_valid`, `out_data` and `out_last` are combinational muxes of the granted requester.
  - `req_ready[i] = out_ready & grant[i]`. Non-granted requesters see `req_ready` = 0.
  - A byte transfers when `out_valid & out_ready`.
  - A transfer with `out_last` pulses `frame_done` in that cycle. Next state is DRAIN and `grant` clears.
  - Gap counter (8 bits):
    - Increments each GRANT cycle with the granted `req_valid` low.
    - Clears on each transfer and on entry to GRANT.
    - When it reaches `MAX_GAP`, pulse `out_abort` next cycle, clear `grant`, go to DRAIN.
  - `rx_active` rising during GRANT does not interrupt the frame.
- DRAIN:
  - Occupied for at least 1 cycle.
  - Returns to IDLE on the first cycle with `tx_busy` = 0. DRAIN covers `tx_busy` rising one cycle late.
- Outside GRANT, `out_valid`, `out_last`, `req_ready` and `grant` are 0. `out_data` is 0.
- `out_append_crc` holds from grant until the next grant. Its reset value is 0.
- Winner selection uses fixed priority, lowest index first, unless round-robin is compiled in (see Configuration).
- Reset mid-frame: the next edge with `rst_n` low forces IDLE. All outputs and counters go to 0. No `out_abort` is issued; `framing` is reset by the same signal.

## Timing
- Grant latency: a request is seen in IDLE in cycle N; `grant` and `out_valid` are high in N+1.
- Data path: mux only, so there are zero cycles from requester to `out_*`.
- Back-to-back frames:
  - Last transfer in cycle T, DRAIN in T+1, IDLE in T+2 if `tx_busy` is low, next grant in T+3.
- Abort: the gap counter equals `MAX_GAP` at the end of cycle G; `out_abort` is high in G+1 and the state is DRAIN in G+1.
- A simultaneous last transfer and counter limit cannot occur, because the transfer clears the counter. Last-transfer handling takes precedence.
- `rx_active` or `tx_busy` high in IDLE holds all requests pending with no grant. Requesters keep `req_valid` high.

## Configuration
- `TX_ARB_ROUND_ROBIN_EN` defined:
  - A registered pointer `last_grant` is updated at each grant.
  - The search starts at `last_grant+1`, wraps modulo `NUM_REQ` and covers all indices.
  - `last_grant` resets to `NUM_REQ-1`, so the first search starts at index 0.
- `TX_ARB_ROUND_ROBIN_EN` undefined: fixed priority, index 0 highest. The pointer register is not instantiated.

## Test plan
- Single frame:
  - Stimulus: requester 1 sends 0x50,0x00 (last) with `append_crc`=1; `out_ready` stays high.
  - Response: `grant`=2'b10 one cycle after the request; two transfers; `out_append_crc`=1; `frame_done` with the 0x00 transfer.
- Contention:
  - Stimulus: both requesters assert in the same IDLE cycle, for three consecutive frames each.
  - Response, fixed priority: grant sequence 0,0,0,1,1,1.
  - Response, `TX_ARB_ROUND_ROBIN_EN`: sequence 0,1,0,1,0,1.
- Gap abort:
  - Stimulus: `MAX_GAP`=4; requester 0 sends one byte, then holds `req_valid` low for 10 cycles.
  - Response: `out_abort` pulses exactly 5 cycles after the transfer; `grant`=0; no `frame_done`.
- Blocking:
  - Stimulus: `rx_active`=1 for 20 cycles with requester 0 pending.
  - Response: no grant during those 20 cycles; grant one cycle after `rx_active` falls.
- Drain:
  - Stimulus: after a last byte, `tx_busy` stays high for 100 cycles while requester 1 is pending.
  - Response: state stays in DRAIN for those 100 cycles; the grant to requester 1 comes 2 cycles after `tx_busy` falls.
- Reset mid-frame:
  - Stimulus: `rst_n` low for 1 cycle during the GRANT state.
  - Response: all outputs are 0 the next cycle; the state is IDLE; no `out_abort` or `frame_done` pulse.
